// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// Imported by instr_fetch_unit and its fetch_buffer2 sub-module.
package instr_fetch_unit_pkg;

    localparam int unsigned PcWidth   = 16;
    localparam int unsigned InstWidth = 16;

    localparam logic [PcWidth-1:0] DefaultResetPc = 16'h0000;
    localparam logic [PcWidth-1:0] DefaultPcInc   = 16'd2;
    localparam logic [4:0]         DefaultHaltOpc = 5'b00000;
    localparam logic [4:0]         NopOpc         = 5'b11111;

    typedef enum logic [1:0] {
        StRun,
        StHaltPend,
        StHalted
    } fetchState_e;

    typedef struct packed {
        logic [PcWidth-1:0]   pc;
        logic [InstWidth-1:0] inst;
    } fetchEntry_t;

    function automatic logic opcodeIs(logic [InstWidth-1:0] inst, logic [4:0] opc);
        return inst[InstWidth-1 -: 5] == opc;
    endfunction

endpackage

// File: rtl/fetch_buffer2.sv
// Two-entry FIFO of {pc, inst} between fetch and decode.
// Flush dominates push and pop; the head is always driven from storage.
module fetch_buffer2
    import instr_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  fetchEntry_t pushEntry_i,
    input  logic        pop_i,
    input  logic        flush_i,
    output logic [1:0]  count_o,
    output fetchEntry_t head_o
);

    fetchEntry_t mem_q [2];
    logic        rdPtr_q;
    logic        wrPtr_q;
    logic [1:0]  count_q;
    logic        doPop;
    logic        doPush;

    always_comb begin
        doPop  = pop_i && (count_q != 2'd0);
        doPush = push_i && ((count_q != 2'd2) || doPop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rdPtr_q  <= 1'b0;
            wrPtr_q  <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rdPtr_q <= 1'b0;
            wrPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= pushEntry_i;
                wrPtr_q        <= ~wrPtr_q;
            end
            if (doPop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_q + {1'b0, doPush} - {1'b0, doPop};
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rdPtr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues single-cycle imem reads and hands {pc, inst, pc+2}
// to decode through a 2-entry buffer, with redirect squash and HALT stop.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [PcWidth-1:0] RESET_PC = DefaultResetPc,
    parameter logic [4:0]         HALT_OPC = DefaultHaltOpc,
    parameter logic [PcWidth-1:0] PC_INC   = DefaultPcInc
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [PcWidth-1:0]   imem_addr,
    input  logic [InstWidth-1:0] imem_rdata,
    input  logic                 redirect_valid,
    input  logic [PcWidth-1:0]   redirect_pc,
    input  logic                 id_ready,
    output logic                 if_valid,
    output logic [PcWidth-1:0]   if_pc,
    output logic [InstWidth-1:0] if_inst,
    output logic [PcWidth-1:0]   if_pc_plus2,
    output logic                 halted
);

    fetchState_e        state_q, state_d;
    logic [PcWidth-1:0] fetchPc_q, fetchPc_d;
    logic [PcWidth-1:0] outPc_q, outPc_d;
    logic               outstanding_q, outstanding_d;

    logic [1:0]  bufCount;
    fetchEntry_t bufHead;
    fetchEntry_t pushEntry;
    logic        redirect;
    logic        push;
    logic        pop;
    logic        haltPush;
    logic        haltPop;
    logic [1:0]  inFlight;
    logic        issue;

    // Redirects are dead once HALT has been accepted.
    assign redirect  = redirect_valid && (state_q != StHalted);
    assign push      = outstanding_q && !redirect;
    assign pop       = if_valid && id_ready;
    assign haltPush  = push && opcodeIs(imem_rdata, HALT_OPC);
    assign haltPop   = pop && opcodeIs(bufHead.inst, HALT_OPC);
    assign pushEntry = '{pc: outPc_q, inst: imem_rdata};

    // Credit counts the entry leaving this cycle so a full-speed stream keeps issuing.
    assign inFlight = bufCount - {1'b0, pop} + {1'b0, outstanding_q};
    assign issue    = (state_q == StRun) && !redirect_valid && (inFlight < 2'd2) && !haltPush;

    fetch_buffer2 u_buffer (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pushEntry_i (pushEntry),
        .pop_i       (pop),
        .flush_i     (redirect),
        .count_o     (bufCount),
        .head_o      (bufHead)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = StRun;
        end else begin
            unique case (state_q)
                StRun:      if (haltPush) state_d = StHaltPend;
                StHaltPend: if (haltPop)  state_d = StHalted;
                StHalted:   state_d = StHalted;
                default:    state_d = StRun;
            endcase
        end
    end

    always_comb begin
        imem_req    = rst && issue;
        imem_addr   = fetchPc_q;
        halted      = (state_q == StHalted);
        if_valid    = (bufCount != 2'd0) && (state_q != StHalted);
        if_pc       = if_valid ? bufHead.pc : '0;
        if_inst     = if_valid ? bufHead.inst : '0;
        if_pc_plus2 = if_valid ? bufHead.pc + PC_INC : '0;
    end

    always_comb begin
        fetchPc_d     = fetchPc_q;
        outPc_d       = outPc_q;
        outstanding_d = issue;
        if (redirect) begin
            fetchPc_d = redirect_pc;
        end else if (issue) begin
            outPc_d   = fetchPc_q;
            fetchPc_d = fetchPc_q + PC_INC;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc_q     <= RESET_PC;
            outPc_q       <= '0;
            outstanding_q <= 1'b0;
        end else begin
            fetchPc_q     <= fetchPc_d;
            outPc_q       <= outPc_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: stream, back-pressure, HALT, redirect, wrap, reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [15:0] if_pc;
    logic [15:0] if_inst;
    logic [15:0] if_pc_plus2;
    logic        halted;

    logic [15:0] haltAddr;
    int          vecCount;
    int          errCount;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_pc_plus2    (if_pc_plus2),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle instruction memory: HALT at haltAddr, 16'h4001 elsewhere.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= (imem_addr == haltAddr) ? 16'h0000 : 16'h4001;
        else          imem_rdata <= 16'hDEAD;
    end

    task automatic cycle(input logic rdy, input logic redir, input logic [15:0] rpc);
        @(negedge clk);
        id_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic restart(input logic [15:0] hAddr);
        @(negedge clk);
        rst            = 1'b0;
        haltAddr       = hAddr;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst            = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        haltAddr       = 16'h000A;
        repeat (2) @(negedge clk);
        #1;
        vecCount++;
        if ({imem_req, if_valid, halted} !== 3'b000 || imem_addr !== 16'h0000 ||
            if_pc !== 16'h0000 || if_inst !== 16'h0000 || if_pc_plus2 !== 16'h0000) begin
            errCount++;
            $display("FAIL reset_outputs: req=%b valid=%b halted=%b addr=%h pc=%h inst=%h pc2=%h, want all 0",
                     imem_req, if_valid, halted, imem_addr, if_pc, if_inst, if_pc_plus2);
        end
    endtask

    task automatic test_stream();
        logic [15:0] expAddr [4];
        expAddr = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) cycle(1'b1, 1'b0, 16'h0000);
            vecCount++;
            if (imem_req !== 1'b1 || imem_addr !== expAddr[c]) begin
                errCount++;
                $display("FAIL stream_issue_c%0d: req=%b addr=%h, want 1/%h", c, imem_req, imem_addr, expAddr[c]);
            end
            vecCount++;
            if (c < 2 && if_valid !== 1'b0) begin
                errCount++;
                $display("FAIL stream_latency_c%0d: valid=%b, want 0", c, if_valid);
            end else if (c >= 2 && (if_valid !== 1'b1 || if_pc !== 16'(2 * (c - 2)) ||
                         if_pc_plus2 !== 16'(2 * (c - 1)) || if_inst !== 16'h4001)) begin
                errCount++;
                $display("FAIL stream_deliver_c%0d: valid=%b pc=%h pc2=%h inst=%h, want 1/%h/%h/4001",
                         c, if_valid, if_pc, if_pc_plus2, if_inst, 16'(2 * (c - 2)), 16'(2 * (c - 1)));
            end
        end
    endtask

    task automatic test_backpressure();
        for (int c = 4; c < 8; c++) begin
            cycle(1'b0, 1'b0, 16'h0000);
            vecCount++;
            if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 16'h0004 || if_pc_plus2 !== 16'h0006) begin
                errCount++;
                $display("FAIL backpressure_hold_c%0d: req=%b valid=%b pc=%h pc2=%h, want 0/1/0004/0006",
                         c, imem_req, if_valid, if_pc, if_pc_plus2);
            end
        end
        cycle(1'b1, 1'b0, 16'h0000);
        vecCount++;
        if (if_pc !== 16'h0004 || imem_req !== 1'b1 || imem_addr !== 16'h0008) begin
            errCount++;
            $display("FAIL backpressure_release: pc=%h req=%b addr=%h, want 0004/1/0008", if_pc, imem_req, imem_addr);
        end
        cycle(1'b1, 1'b0, 16'h0000);
        vecCount++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0006 || imem_req !== 1'b1 || imem_addr !== 16'h000A) begin
            errCount++;
            $display("FAIL backpressure_second: valid=%b pc=%h req=%b addr=%h, want 1/0006/1/000A",
                     if_valid, if_pc, imem_req, imem_addr);
        end
    endtask

    task automatic test_halt();
        cycle(1'b1, 1'b0, 16'h0000);
        vecCount++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0008 || imem_req !== 1'b0) begin
            errCount++;
            $display("FAIL halt_push_stop: valid=%b pc=%h req=%b, want 1/0008/0", if_valid, if_pc, imem_req);
        end
        cycle(1'b1, 1'b0, 16'h0000);
        vecCount++;
        if (if_valid !== 1'b1 || if_pc !== 16'h000A || if_inst !== 16'h0000 || imem_req !== 1'b0 || halted !== 1'b0) begin
            errCount++;
            $display("FAIL halt_pending: valid=%b pc=%h inst=%h req=%b halted=%b, want 1/000A/0000/0/0",
                     if_valid, if_pc, if_inst, imem_req, halted);
        end
        for (int c = 0; c < 20; c++) begin
            cycle(1'b1, (c == 5), 16'h0040);
            vecCount++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
                errCount++;
                $display("FAIL halted_c%0d: halted=%b req=%b valid=%b, want 1/0/0", c, halted, imem_req, if_valid);
            end
        end
    endtask

    task automatic test_redirect();
        restart(16'hFFFF);
        repeat (3) cycle(1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 16'h0100);
        vecCount++;
        if (imem_req !== 1'b0) begin
            errCount++;
            $display("FAIL redirect_no_issue: req=%b, want 0", imem_req);
        end
        cycle(1'b1, 1'b0, 16'h0000);
        vecCount++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0100 || if_valid !== 1'b0) begin
            errCount++;
            $display("FAIL redirect_target_issue: req=%b addr=%h valid=%b, want 1/0100/0", imem_req, imem_addr, if_valid);
        end
        cycle(1'b1, 1'b0, 16'h0000);
        vecCount++;
        if (if_valid !== 1'b0 || imem_addr !== 16'h0102) begin
            errCount++;
            $display("FAIL redirect_squash: valid=%b pc=%h addr=%h, want 0/-/0102", if_valid, if_pc, imem_addr);
        end
        cycle(1'b1, 1'b0, 16'h0000);
        vecCount++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0100 || if_pc_plus2 !== 16'h0102) begin
            errCount++;
            $display("FAIL redirect_first_pc: valid=%b pc=%h pc2=%h, want 1/0100/0102", if_valid, if_pc, if_pc_plus2);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 1'b1, 16'hFFFC);
        cycle(1'b1, 1'b0, 16'h0000);
        vecCount++;
        if (imem_req !== 1'b1 || imem_addr !== 16'hFFFC) begin
            errCount++;
            $display("FAIL wrap_issue_fffc: req=%b addr=%h, want 1/FFFC", imem_req, imem_addr);
        end
        cycle(1'b1, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 16'h0000);
        vecCount++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || if_pc !== 16'hFFFC) begin
            errCount++;
            $display("FAIL wrap_issue_0000: req=%b addr=%h pc=%h, want 1/0000/FFFC", imem_req, imem_addr, if_pc);
        end
        cycle(1'b1, 1'b0, 16'h0000);
        vecCount++;
        if (if_pc !== 16'hFFFE || if_pc_plus2 !== 16'h0000) begin
            errCount++;
            $display("FAIL wrap_pc_plus2: pc=%h pc2=%h, want FFFE/0000", if_pc, if_pc_plus2);
        end
    endtask

    task automatic test_wrong_path_halt();
        restart(16'h0006);
        repeat (3) cycle(1'b1, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 16'h0000);
        vecCount++;
        if (imem_req !== 1'b0 || if_pc !== 16'h0004) begin
            errCount++;
            $display("FAIL wrongpath_halt_seen: req=%b pc=%h, want 0/0004", imem_req, if_pc);
        end
        cycle(1'b1, 1'b1, 16'h0020);
        vecCount++;
        if (if_pc !== 16'h0006 || if_inst !== 16'h0000 || imem_req !== 1'b0) begin
            errCount++;
            $display("FAIL wrongpath_pending: pc=%h inst=%h req=%b, want 0006/0000/0", if_pc, if_inst, imem_req);
        end
        cycle(1'b1, 1'b0, 16'h0000);
        vecCount++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0020 || halted !== 1'b0 || if_valid !== 1'b0) begin
            errCount++;
            $display("FAIL wrongpath_resume: req=%b addr=%h halted=%b valid=%b, want 1/0020/0/0",
                     imem_req, imem_addr, halted, if_valid);
        end
        cycle(1'b1, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 16'h0000);
        vecCount++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0020 || halted !== 1'b0) begin
            errCount++;
            $display("FAIL wrongpath_next_pc: valid=%b pc=%h halted=%b, want 1/0020/0", if_valid, if_pc, halted);
        end
    endtask

    task automatic test_reset_halt_pend();
        restart(16'h0006);
        repeat (4) cycle(1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000);
        vecCount++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0006 || imem_req !== 1'b0) begin
            errCount++;
            $display("FAIL rstpend_setup: valid=%b pc=%h req=%b, want 1/0006/0", if_valid, if_pc, imem_req);
        end
        #2 rst = 1'b0;
        #1;
        vecCount++;
        if ({imem_req, if_valid, halted} !== 3'b000 || imem_addr !== 16'h0000 ||
            if_pc !== 16'h0000 || if_inst !== 16'h0000 || if_pc_plus2 !== 16'h0000) begin
            errCount++;
            $display("FAIL rstpend_async: req=%b valid=%b halted=%b addr=%h pc=%h inst=%h pc2=%h, want all 0",
                     imem_req, if_valid, halted, imem_addr, if_pc, if_inst, if_pc_plus2);
        end
        @(negedge clk);
        rst      = 1'b1;
        id_ready = 1'b1;
        #1;
        vecCount++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || if_valid !== 1'b0) begin
            errCount++;
            $display("FAIL rstpend_restart: req=%b addr=%h valid=%b, want 1/0000/0", imem_req, imem_addr, if_valid);
        end
        cycle(1'b1, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 16'h0000);
        vecCount++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_inst !== 16'h4001) begin
            errCount++;
            $display("FAIL rstpend_first_pc: valid=%b pc=%h inst=%h, want 1/0000/4001", if_valid, if_pc, if_inst);
        end
    endtask

    initial begin
        vecCount = 0;
        errCount = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_halt();
        test_redirect();
        test_wrap();
        test_wrong_path_halt();
        test_reset_halt_pend();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
